// File: rtl/mont_domain_entry.sv
// mont_domain_entry: bit-serial conversion of base and 1 into the Montgomery domain
// (base*2^BITS mod N and 2^BITS mod N) using shift and conditional subtract only.
module mont_domain_entry #(
    parameter int BITS     = 8,
    parameter int CNT_BITS = $clog2(BITS) + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [BITS-1:0] base,
    input  logic [BITS-1:0] N,
    output logic            busy,
    output logic            finish,
    output logic            error,
    output logic [BITS-1:0] base_mont,
    output logic [BITS-1:0] one_mont
);
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_RUN  = 3'd1;
    localparam logic [2:0] S_FIN  = 3'd7;

    logic [2:0]          r_state;
    logic [CNT_BITS-1:0] r_cnt;
    logic [BITS-1:0]     r_base, r_n, r_acc_b, r_acc_o;
    logic                r_error;

    logic [CNT_BITS-1:0] w_idx;
    logic [BITS-1:0]     w_sh, w_nb, w_no;
    logic                w_hi, w_b_bit, w_o_bit;
    logic [BITS:0]       w_tb, w_to, w_db, w_do, w_nx;

    // Stream base*2^BITS and 2^BITS MSB-first: base bits occupy counts 2*BITS-1..BITS.
    assign w_hi    = r_cnt >= CNT_BITS'(BITS);
    assign w_idx   = r_cnt - CNT_BITS'(BITS);
    assign w_sh    = r_base >> w_idx;
    assign w_b_bit = w_hi & w_sh[0];
    assign w_o_bit = r_cnt == CNT_BITS'(BITS);

    // acc < N keeps t <= 2N-1, so a single conditional subtract restores the invariant.
    assign w_nx = {1'b0, r_n};
    assign w_tb = {r_acc_b, 1'b0} + {{BITS{1'b0}}, w_b_bit};
    assign w_to = {r_acc_o, 1'b0} + {{BITS{1'b0}}, w_o_bit};
    assign w_db = w_tb - w_nx;
    assign w_do = w_to - w_nx;
    assign w_nb = (w_tb >= w_nx) ? w_db[BITS-1:0] : w_tb[BITS-1:0];
    assign w_no = (w_to >= w_nx) ? w_do[BITS-1:0] : w_to[BITS-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '1;
            r_base  <= '0;
            r_n     <= '0;
            r_acc_b <= '0;
            r_acc_o <= '0;
            r_error <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (start) begin
                    r_base  <= base;
                    r_n     <= N;
                    r_acc_b <= '0;
                    r_acc_o <= '0;
                    r_error <= ~N[0];
                    r_state <= N[0] ? S_RUN : S_FIN;
                    if (N[0]) r_cnt <= CNT_BITS'(2 * BITS - 1);
                end
                S_RUN: begin
                    r_acc_b <= w_nb;
                    r_acc_o <= w_no;
                    if (r_cnt == '0) r_state <= S_FIN;
                    else r_cnt <= r_cnt - 1'b1;
                end
                S_FIN: begin
                    r_state <= S_IDLE;
                    r_cnt   <= '1;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy      = r_state != S_IDLE;
    assign finish    = r_state == S_FIN;
    assign error     = r_error;
    assign base_mont = r_acc_b;
    assign one_mont  = r_acc_o;
endmodule
